// File: rtl/mango1_pkg.sv
// Shared constants and types for the Mango One keyboard front end:
// set-2 scancodes, ASCII control codes and the PS/2 frame state encoding.
package mango1_pkg;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_BKSP   = 8'h66;
  localparam logic [7:0] SC_ESC    = 8'h76;
  localparam logic [7:0] SC_SPACE  = 8'h29;

  localparam logic [6:0] CR     = 7'h0D;
  localparam logic [6:0] RUBOUT = 7'h5F;
  localparam logic [6:0] ESC    = 7'h1B;
  localparam logic [6:0] SPACE  = 7'h20;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frame_state_e;

  function automatic logic is_shift(input logic [7:0] sc);
    return (sc == SC_LSHIFT) || (sc == SC_RSHIFT);
  endfunction

endpackage

// File: rtl/ps2_scancode_ascii.sv
// Set-2 make code to 7-bit uppercase ASCII (Apple-I style). Purely
// combinational; an output of zero means the scancode is unmapped.
module ps2_scancode_ascii
  import mango1_pkg::*;
(
  input  logic [7:0] scancode,
  input  logic       shift,
  output logic [6:0] ascii
);

  always_comb begin
    // NOTE: default first so every path assigns ascii and no latch is inferred.
    ascii = 7'h00;
    case (scancode)
      8'h1C: ascii = 7'h41;  8'h32: ascii = 7'h42;  8'h21: ascii = 7'h43;
      8'h23: ascii = 7'h44;  8'h24: ascii = 7'h45;  8'h2B: ascii = 7'h46;
      8'h34: ascii = 7'h47;  8'h33: ascii = 7'h48;  8'h43: ascii = 7'h49;
      8'h3B: ascii = 7'h4A;  8'h42: ascii = 7'h4B;  8'h4B: ascii = 7'h4C;
      8'h3A: ascii = 7'h4D;  8'h31: ascii = 7'h4E;  8'h44: ascii = 7'h4F;
      8'h4D: ascii = 7'h50;  8'h15: ascii = 7'h51;  8'h2D: ascii = 7'h52;
      8'h1B: ascii = 7'h53;  8'h2C: ascii = 7'h54;  8'h3C: ascii = 7'h55;
      8'h2A: ascii = 7'h56;  8'h1D: ascii = 7'h57;  8'h22: ascii = 7'h58;
      8'h35: ascii = 7'h59;  8'h1A: ascii = 7'h5A;
      // Shifted digits follow the Apple layout; shift-0 stays '0'.
      8'h45: ascii = 7'h30;
      8'h16: ascii = shift ? 7'h21 : 7'h31;
      8'h1E: ascii = shift ? 7'h22 : 7'h32;
      8'h26: ascii = shift ? 7'h23 : 7'h33;
      8'h25: ascii = shift ? 7'h24 : 7'h34;
      8'h2E: ascii = shift ? 7'h25 : 7'h35;
      8'h36: ascii = shift ? 7'h26 : 7'h36;
      8'h3D: ascii = shift ? 7'h27 : 7'h37;
      8'h3E: ascii = shift ? 7'h28 : 7'h38;
      8'h46: ascii = shift ? 7'h29 : 7'h39;
      8'h41: ascii = shift ? 7'h3C : 7'h2C;
      8'h49: ascii = shift ? 7'h3E : 7'h2E;
      8'h4A: ascii = shift ? 7'h3F : 7'h2F;
      8'h4C: ascii = shift ? 7'h3A : 7'h3B;
      8'h55: ascii = shift ? 7'h2B : 7'h3D;
      8'h4E: ascii = shift ? 7'h2A : 7'h2D;
      SC_SPACE: ascii = SPACE;
      SC_ENTER: ascii = CR;
      SC_BKSP:  ascii = RUBOUT;
      SC_ESC:   ascii = ESC;
      default:  ascii = 7'h00;
    endcase
  end

endmodule

// File: rtl/ps2_keyboard_latch.sv
// PS/2 keyboard receiver presenting an Apple-I style key register
// {available, ascii}. Define PS2_TYPEAHEAD_EN to replace the single key
// register with a FIFO_DEPTH-entry typeahead FIFO.
module ps2_keyboard_latch
  import mango1_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4096
`ifdef PS2_TYPEAHEAD_EN
  , parameter int unsigned FIFO_DEPTH = 4
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       keystrobe,
  output logic [7:0] keycode,
  output logic       frame_err,
  output logic       overrun
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  // Synchronizers reset high (the idle level) so release never fakes an edge.
  logic [1:0] clk_sync, data_sync;
  logic       clk_prev;
  logic       fall, bit_in;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_prev  <= 1'b1;
    end else begin
      // NOTE: non-blocking so each stage samples the previous stage's old value.
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      clk_prev  <= clk_sync[1];
    end
  end

  assign fall   = clk_prev & ~clk_sync[1];
  assign bit_in = data_sync[1];

  frame_state_e    state;
  logic [2:0]      bitcnt;
  logic [7:0]      shreg;
  logic            par_bit;
  logic [TO_W-1:0] to_cnt;
  logic            byte_stb;
  logic [7:0]      byte_val;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      bitcnt    <= '0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      to_cnt    <= '0;
      byte_stb  <= 1'b0;
      byte_val  <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      byte_stb  <= 1'b0;
      if (state == IDLE) begin
        to_cnt <= '0;
        if (fall) begin
          if (!bit_in) begin
            state  <= DATA;
            bitcnt <= '0;
            shreg  <= '0;
          end else begin
            frame_err <= 1'b1;
          end
        end
      end else if (fall) begin
        to_cnt <= '0;
        case (state)
          DATA: begin
            shreg  <= {bit_in, shreg[7:1]};
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par_bit <= bit_in;
            state   <= STOP;
          end
          STOP: begin
            if (bit_in && (^{shreg, par_bit})) begin
              byte_stb <= 1'b1;
              byte_val <= shreg;
            end else begin
              frame_err <= 1'b1;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end else if (to_cnt == TO_LAST) begin
        state     <= IDLE;
        frame_err <= 1'b1;
        shreg     <= '0;
        bitcnt    <= '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

  logic       shift, break_pending, ext_pending;
  logic [6:0] xlat;
  logic       push;
  logic [6:0] push_ascii;

  ps2_scancode_ascii u_xlat (
    .scancode (byte_val),
    .shift    (shift),
    .ascii    (xlat)
  );

  // Prefix bytes, releases and shift keys never produce a character.
  always_comb begin
    push       = 1'b0;
    push_ascii = xlat;
    if (byte_stb && byte_val != SC_BREAK && byte_val != SC_EXT &&
        !break_pending && !is_shift(byte_val)) begin
      if (ext_pending) begin
        push       = (byte_val == SC_ENTER);
        push_ascii = CR;
      end else begin
        push = (xlat != 7'h00);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift         <= 1'b0;
      break_pending <= 1'b0;
      ext_pending   <= 1'b0;
    end else if (byte_stb) begin
      if (byte_val == SC_BREAK) begin
        break_pending <= 1'b1;
      end else if (byte_val == SC_EXT) begin
        ext_pending <= 1'b1;
      end else if (break_pending) begin
        if (is_shift(byte_val)) shift <= 1'b0;
        break_pending <= 1'b0;
        ext_pending   <= 1'b0;
      end else if (is_shift(byte_val)) begin
        shift <= 1'b1;
      end else if (ext_pending) begin
        ext_pending <= 1'b0;
      end
    end
  end

  logic strobe_prev, strobe_rise;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) strobe_prev <= 1'b0;
    else        strobe_prev <= keystrobe;
  end

  assign strobe_rise = keystrobe & ~strobe_prev;

`ifdef PS2_TYPEAHEAD_EN
  localparam int PW = $clog2(FIFO_DEPTH);

  logic [6:0]  mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic [6:0]    last;
  logic          empty, full, pop, wr;

  assign empty = (count == '0);
  assign full  = (count == (PW+1)'(FIFO_DEPTH));
  assign pop   = strobe_rise & ~empty;
  assign wr    = push & (~full | pop);

  // NOTE: the storage array is not reset; count and the pointers alone say
  // which entries are valid, and an empty FIFO never shows mem contents.
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= push_ascii;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      last    <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= push & ~wr;
      if (wr)  wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        last   <= mem[rd_ptr];
      end
      case ({wr, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign keycode = {~empty, empty ? last : mem[rd_ptr]};
`else
  logic       avail;
  logic [6:0] key;

  // A clear and a push in the same cycle: the clear wins first, then the push loads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      avail   <= 1'b0;
      key     <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (push) begin
        if (avail && !strobe_rise) begin
          overrun <= 1'b1;
        end else begin
          avail <= 1'b1;
          key   <= push_ascii;
        end
      end else if (strobe_rise) begin
        avail <= 1'b0;
      end
    end
  end

  assign keycode = {avail, key};
`endif

endmodule
